ttt_game_engine: RTL and testbench
==================================

Name: ttt_game_engine

Overview:
- Parametrised successor to the two-player board-marking block.
- Holds an N×N board with per-player occupancy and alternates turns internally.
- Rejects illegal moves with a nack, detects a K-in-a-row win on any row, column or diagonal window, and detects a draw.
- Sits between the move-input decoder (switch/button front end) and the display driver. The display driver consumes the occupancy vectors and the game status.

Parameters:
N, 3, board side length (≥3); CELLS = N*N
K, 3, run length required to win (3 ≤ K ≤ N)
IDX_W, $clog2(N*N), width of cell index (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
new_game  in  1  synchronous clear of board and status, any state
move_valid  in  1  move request strobe, one cycle
move_idx  in  IDX_W  target cell, idx = row*N + col, row 0 = top
move_ack  out  1  one-cycle pulse: move accepted
move_nack  out  1  one-cycle pulse: move rejected
occ_p1  out  N*N  cells owned by player 1
occ_p2  out  N*N  cells owned by player 2
cur_player  out  1  0 = player 1 to move, 1 = player 2 to move
move_count  out  $clog2(N*N+1)  number of occupied cells
state  out  2  game_state_e: PLAY=0, EVAL=1, WIN=2, DRAW=3
winner  out  1  valid only in WIN; 0 = player 1, 1 = player 2

Behaviour:
- Reset (asynchronous assert): occ_p1 = occ_p2 = 0, cur_player = 0, move_count = 0, state = PLAY, winner = 0, move_ack = move_nack = 0.
- new_game (synchronous): same values as reset on the next edge. It has priority over move_valid in the same cycle; no ack or nack is issued for that move.
- PLAY, move_valid = 1: the move is legal iff move_idx < CELLS and the cell is free in both occupancy vectors.
  - Legal: next edge sets the cell bit of cur_player, increments move_count, pulses move_ack, and enters EVAL.
  - Illegal: pulses move_nack; board, player and state are unchanged.
- EVAL lasts exactly one cycle. Win detection runs on the registered occupancy of the player who just moved. Priority order:
  1. Any K-long window is fully owned (horizontal, vertical, down-right diagonal, down-left diagonal) → WIN, winner = that player.
  2. Otherwise move_count == CELLS → DRAW.
  3. Otherwise → PLAY, with cur_player toggled.
- A win on the final cell reports WIN, not DRAW.
- Any move_valid in EVAL, WIN or DRAW pulses move_nack with no state change.
- WIN and DRAW are terminal until new_game or reset.
- Latency: request edge → ack and board update at +1 edge; status at +2 edges.
- Ack and nack are mutually exclusive and never asserted for two consecutive cycles from a single request.
- move_valid held high for multiple cycles is treated as one request per cycle. The 2nd cycle lands in EVAL and is nacked.
- Reset mid-EVAL discards the evaluation. No win is reported.

Optional Feature:
- Macro: TTT_UNDO_EN. Adds input undo (1 bit) and a registered last-move record (index plus valid bit).
- With the macro defined:
  - undo in PLAY with a valid record clears that cell, decrements move_count, toggles cur_player back, clears the record, and pulses move_ack.
  - undo with no record, or in any state other than PLAY, pulses move_nack.
  - undo and move_valid in the same cycle: undo wins and the move is nacked.
  - Only one level of undo exists; new_game and reset clear the record.
- Without the macro: no undo port and no record logic.

Decomposition:
- ttt_pkg holds:
  - game_state_e (2-bit enum)
  - player_t (1-bit)
  - function cells(N)
  - localparams for direction encodings.
- Sub-module ttt_line_checker #(N,K): combinational; takes an N*N occupancy vector and returns win. Built with generate loops over all window origins in all 4 directions. The engine instantiates it once on the mover's occupancy, selected by cur_player.

Test Plan:
- N=3, K=3: P1 plays 0, P2 plays 3, P1 plays 1, P2 plays 4, P1 plays 2 → acks each time, state WIN at +2 after the last move, winner = 0, occ_p1 = 9'b000000111.
- Play to the same cell 4 twice → 2nd request move_nack = 1, occ unchanged, cur_player unchanged; move_idx = 9 → nack.
- Moves 4,0,2,6,3,5,1,7,8 (no line) → state DRAW after the 9th move, move_count = 9; a further move → nack.
- N=5, K=4: P2 completes anti-diagonal cells 4,8,12,16 → WIN, winner = 1; a 3-long run alone gives no win.
- Assert reset asynchronously in the cycle after an ack (in EVAL) → all outputs are zero immediately, state PLAY; new_game asserted with move_valid → board cleared, no ack.
- TTT_UNDO_EN: move 4, then undo → occ 0, move_count 0, cur_player 0, ack; a second undo → nack.

Source files
------------

// File: rtl/ttt_pkg.sv
// ============================================================================
// Module      : ttt_pkg
// Description : Shared types, window direction encodings and helpers for the
//               tic-tac-toe game engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      EVAL = 2'd1,
      WIN  = 2'd2,
      DRAW = 2'd3
   } game_state_e;

   typedef logic player_t;

   localparam int DIR_H    = 0;   // left to right
   localparam int DIR_V    = 1;   // top to bottom
   localparam int DIR_DR   = 2;   // down-right diagonal
   localparam int DIR_DL   = 3;   // down-left diagonal
   localparam int NUM_DIRS = 4;

   function automatic int cells(input int n);
      return n * n;
   endfunction

   function automatic int dir_drow(input int d);
      return (d == DIR_H) ? 0 : 1;
   endfunction

   function automatic int dir_dcol(input int d);
      return (d == DIR_V) ? 0 : ((d == DIR_DL) ? -1 : 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_line_checker.sv
// ============================================================================
// Module      : ttt_line_checker
// Description : Combinational K-in-a-row detector over an N x N occupancy map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_line_checker
   import ttt_pkg::*;
#(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic [N*N-1:0] occ,
   output logic           win
);

   localparam int CELLS = cells(N);

   // One hit bit per (direction, origin); origins whose window leaves the board tie low.
   logic [NUM_DIRS*CELLS-1:0] w_hit;

   for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
      for (genvar r = 0; r < N; r++) begin : g_row
         for (genvar c = 0; c < N; c++) begin : g_col
            localparam int DRW = dir_drow(d);
            localparam int DCL = dir_dcol(d);
            localparam int ER  = r + (K - 1) * DRW;
            localparam int EC  = c + (K - 1) * DCL;
            if (ER < N && EC >= 0 && EC < N) begin : g_win
               logic [K-1:0] w_bits;
               for (genvar k = 0; k < K; k++) begin : g_cell
                  assign w_bits[k] = occ[(r + k * DRW) * N + (c + k * DCL)];
               end
               assign w_hit[d*CELLS + r*N + c] = &w_bits;
            end else begin : g_none
               assign w_hit[d*CELLS + r*N + c] = 1'b0;
            end
         end
      end
   end

   assign win = |w_hit;

endmodule

`default_nettype wire

// File: rtl/ttt_game_engine.sv
// ============================================================================
// Module      : ttt_game_engine
// Description : N x N board, turn alternation, move legality, win/draw status.
//               Optional macro TTT_UNDO_EN adds a single-level undo input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_game_engine
   import ttt_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int K     = 3,
   localparam int IDX_W = $clog2(N*N),
   localparam int CNT_W = $clog2(N*N+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              new_game,
   input  logic              move_valid,
   input  logic [IDX_W-1:0]  move_idx,
`ifdef TTT_UNDO_EN
   input  logic              undo,
`endif
   output logic              move_ack,
   output logic              move_nack,
   output logic [N*N-1:0]    occ_p1,
   output logic [N*N-1:0]    occ_p2,
   output player_t           cur_player,
   output logic [CNT_W-1:0]  move_count,
   output game_state_e       state,
   output player_t           winner
);

   localparam int             CELLS = cells(N);
   localparam logic [CELLS-1:0] C_ONE = {{(CELLS-1){1'b0}}, 1'b1};

   logic [CELLS-1:0] w_mask;
   logic             w_in_range;
   logic             w_legal;
   logic [CELLS-1:0] w_mover_occ;
   logic             w_win;
   logic             w_req;

   assign w_mask      = C_ONE << move_idx;
   assign w_in_range  = {1'b0, move_idx} < (IDX_W+1)'(CELLS);
   assign w_legal     = w_in_range && (((occ_p1 | occ_p2) & w_mask) == '0);
   assign w_mover_occ = cur_player ? occ_p2 : occ_p1;

`ifdef TTT_UNDO_EN
   logic [IDX_W-1:0] r_last_idx;
   logic             r_last_valid;
   logic [CELLS-1:0] w_last_mask;
   assign w_last_mask = C_ONE << r_last_idx;
   assign w_req       = move_valid | undo;
`else
   assign w_req       = move_valid;
`endif

   ttt_line_checker #(.N(N), .K(K)) u_line_checker (
      .occ (w_mover_occ),
      .win (w_win)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ_p1     <= '0;
         occ_p2     <= '0;
         cur_player <= 1'b0;
         move_count <= '0;
         state      <= PLAY;
         winner     <= 1'b0;
         move_ack   <= 1'b0;
         move_nack  <= 1'b0;
`ifdef TTT_UNDO_EN
         r_last_idx   <= '0;
         r_last_valid <= 1'b0;
`endif
      end else begin
         move_ack  <= 1'b0;
         move_nack <= 1'b0;
         if (new_game) begin
            occ_p1     <= '0;
            occ_p2     <= '0;
            cur_player <= 1'b0;
            move_count <= '0;
            state      <= PLAY;
            winner     <= 1'b0;
`ifdef TTT_UNDO_EN
            r_last_idx   <= '0;
            r_last_valid <= 1'b0;
`endif
         end else begin
            case (state)
               PLAY: begin
`ifdef TTT_UNDO_EN
                  // The last mover is the opposite of the player now on turn.
                  if (undo) begin
                     if (r_last_valid) begin
                        if (cur_player) occ_p1 <= occ_p1 & ~w_last_mask;
                        else            occ_p2 <= occ_p2 & ~w_last_mask;
                        cur_player   <= ~cur_player;
                        move_count   <= move_count - CNT_W'(1);
                        r_last_valid <= 1'b0;
                        move_ack     <= 1'b1;
                     end else begin
                        move_nack <= 1'b1;
                     end
                  end else
`endif
                  if (move_valid) begin
                     if (w_legal) begin
                        if (cur_player) occ_p2 <= occ_p2 | w_mask;
                        else            occ_p1 <= occ_p1 | w_mask;
                        move_count <= move_count + CNT_W'(1);
                        move_ack   <= 1'b1;
                        state      <= EVAL;
`ifdef TTT_UNDO_EN
                        r_last_idx   <= move_idx;
                        r_last_valid <= 1'b1;
`endif
                     end else begin
                        move_nack <= 1'b1;
                     end
                  end
               end
               EVAL: begin
                  move_nack <= w_req;
                  if (w_win) begin
                     state  <= WIN;
                     winner <= cur_player;
                  end else if (move_count == CNT_W'(CELLS)) begin
                     state <= DRAW;
                  end else begin
                     state      <= PLAY;
                     cur_player <= ~cur_player;
                  end
               end
               default: begin
                  move_nack <= w_req;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ttt_game_engine.sv
// ============================================================================
// Module      : tb_ttt_game_engine
// Description : Directed self-checking bench for ttt_game_engine (3x3/K3 and 5x5/K4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ttt_game_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        ng3 = 1'b0, mv3 = 1'b0, undo3 = 1'b0;
   logic [3:0]  idx3 = '0;
   logic        ack3, nack3, cur3, win3;
   logic [8:0]  p1_3, p2_3;
   logic [3:0]  cnt3;
   logic [1:0]  st3;

   logic        ng5 = 1'b0, mv5 = 1'b0, undo5 = 1'b0;
   logic [4:0]  idx5 = '0;
   logic        ack5, nack5, cur5, win5;
   logic [24:0] p1_5, p2_5;
   logic [4:0]  cnt5;
   logic [1:0]  st5;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ttt_game_engine #(.N(3), .K(3)) dut3 (
      .clk(clk), .reset(reset), .new_game(ng3), .move_valid(mv3), .move_idx(idx3),
`ifdef TTT_UNDO_EN
      .undo(undo3),
`endif
      .move_ack(ack3), .move_nack(nack3), .occ_p1(p1_3), .occ_p2(p2_3),
      .cur_player(cur3), .move_count(cnt3), .state(st3), .winner(win3)
   );

   ttt_game_engine #(.N(5), .K(4)) dut5 (
      .clk(clk), .reset(reset), .new_game(ng5), .move_valid(mv5), .move_idx(idx5),
`ifdef TTT_UNDO_EN
      .undo(undo5),
`endif
      .move_ack(ack5), .move_nack(nack5), .occ_p1(p1_5), .occ_p2(p2_5),
      .cur_player(cur5), .move_count(cnt5), .state(st5), .winner(win5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one move; when accepted, also step through the EVAL cycle.
   task automatic move(input bit big, input int idx, input bit exp_ack);
      @(negedge clk);
      if (big) begin mv5 = 1'b1; idx5 = idx[4:0]; end
      else     begin mv3 = 1'b1; idx3 = idx[3:0]; end
      @(posedge clk); #1;
      mv3 = 1'b0; mv5 = 1'b0;
      check($sformatf("ack idx%0d", idx),  big ? ack5  : ack3,  exp_ack);
      check($sformatf("nack idx%0d", idx), big ? nack5 : nack3, !exp_ack);
      if (exp_ack) begin
         check($sformatf("eval idx%0d", idx), big ? st5 : st3, 32'd1);
         @(posedge clk); #1;
      end
   endtask

   task automatic new_game3();
      @(negedge clk); ng3 = 1'b1;
      @(posedge clk); #1; ng3 = 1'b0;
   endtask

   initial begin : stim
      int draw_seq[9];
      draw_seq = '{4, 0, 2, 6, 3, 5, 1, 7, 8};

      #12;
      check("rst occ_p1", p1_3, 0);
      check("rst occ_p2", p2_3, 0);
      check("rst state",  st3, 0);
      check("rst count",  cnt3, 0);
      check("rst ack",    ack3, 0);
      @(negedge clk); reset = 1'b0;

      // Row 0 win for player 1
      move(0, 0, 1); move(0, 3, 1); move(0, 1, 1); move(0, 4, 1); move(0, 2, 1);
      check("win state",  st3, 2);
      check("win winner", win3, 0);
      check("win occ_p1", p1_3, 9'b000000111);
      check("win occ_p2", p2_3, 9'b000011000);
      check("win count",  cnt3, 5);
      move(0, 5, 0);
      check("win sticky", st3, 2);

      // Illegal moves
      new_game3();
      check("ng occ_p1", p1_3, 0);
      check("ng state",  st3, 0);
      move(0, 4, 1);
      move(0, 4, 0);
      check("dup occ_p1", p1_3, 9'b000010000);
      check("dup occ_p2", p2_3, 0);
      check("dup cur",    cur3, 1);
      move(0, 9, 0);
      check("oor count",  cnt3, 1);

      // new_game wins over a simultaneous move
      @(negedge clk); ng3 = 1'b1; mv3 = 1'b1; idx3 = 4'd0;
      @(posedge clk); #1; ng3 = 1'b0; mv3 = 1'b0;
      check("ngmv ack",   ack3, 0);
      check("ngmv nack",  nack3, 0);
      check("ngmv occ",   p1_3 | p2_3, 0);
      check("ngmv count", cnt3, 0);

      // Draw
      foreach (draw_seq[i]) move(0, draw_seq[i], 1);
      check("draw state", st3, 3);
      check("draw count", cnt3, 9);
      check("draw occ_p1", p1_3, 9'b100011110);
      move(0, 0, 0);

      // move_valid held two cycles: second lands in EVAL
      new_game3();
      @(negedge clk); mv3 = 1'b1; idx3 = 4'd0;
      @(posedge clk); #1;
      check("hold ack1", ack3, 1);
      @(posedge clk); #1; mv3 = 1'b0;
      check("hold ack2",  ack3, 0);
      check("hold nack2", nack3, 1);
      check("hold state", st3, 0);
      check("hold occ",   p1_3, 9'b000000001);
      check("hold cur",   cur3, 1);

      // Asynchronous reset during EVAL
      new_game3();
      @(negedge clk); mv3 = 1'b1; idx3 = 4'd4;
      @(posedge clk); #1; mv3 = 1'b0;
      check("ar ack",  ack3, 1);
      check("ar eval", st3, 1);
      #2 reset = 1'b1;
      #1;
      check("ar occ",   p1_3 | p2_3, 0);
      check("ar state", st3, 0);
      check("ar count", cnt3, 0);
      check("ar ack0",  ack3, 0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      check("ar post state",  st3, 0);
      check("ar post winner", win3, 0);

      // 5x5, K=4: three-in-a-row is not enough; anti-diagonal win for player 2
      move(1, 0, 1); move(1, 4, 1); move(1, 1, 1); move(1, 8, 1); move(1, 2, 1);
      check("n5 p1 run3", st5, 0);
      move(1, 12, 1);
      check("n5 p2 run3", st5, 0);
      move(1, 20, 1); move(1, 16, 1);
      check("n5 state",  st5, 2);
      check("n5 winner", win5, 1);
      check("n5 occ_p2", p2_5, 25'h0011110);
      check("n5 count",  cnt5, 8);

`ifdef TTT_UNDO_EN
      new_game3();
      move(0, 4, 1);
      @(negedge clk); undo3 = 1'b1;
      @(posedge clk); #1; undo3 = 1'b0;
      check("undo ack",   ack3, 1);
      check("undo occ",   p1_3 | p2_3, 0);
      check("undo count", cnt3, 0);
      check("undo cur",   cur3, 0);
      @(negedge clk); undo3 = 1'b1;
      @(posedge clk); #1; undo3 = 1'b0;
      check("undo2 nack", nack3, 1);
      check("undo2 ack",  ack3, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
